// File: rtl/booth_mac_acc.sv
// Saturating multiply-accumulate stage behind the sequential Booth multiplier.
// Sums a programmed number of signed products and offers each sum on a valid/ready stream.
module booth_mac_acc #(
    parameter int WIDTH       = 8,
    parameter int ACC_WIDTH   = 24,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         open,
    input  logic                         cont,
    input  logic [COUNT_WIDTH-1:0]       len,
    input  logic                         clear,
    input  logic                         prod_valid,
    input  logic signed [2*WIDTH-1:0]    prod,
    output logic                         busy,
    output logic                         acc_valid,
    input  logic                         acc_ready,
    output logic signed [ACC_WIDTH-1:0]  acc,
    output logic                         acc_sat,
    output logic                         dropped
);

    localparam int PW = 2 * WIDTH;
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [COUNT_WIDTH-1:0]      ONE     = COUNT_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

    state_t                   state, state_nxt;
    logic signed [ACC_WIDTH-1:0] acc_nxt;
    logic [COUNT_WIDTH-1:0]   count, count_nxt;
    logic [COUNT_WIDTH-1:0]   len_r, len_nxt;
    logic                     cont_r, cont_nxt;
    logic signed [PW-1:0]     skid, skid_nxt;
    logic                     skid_full, skid_full_nxt;
    logic                     sat_nxt, drop_nxt;

    logic signed [ACC_WIDTH:0]   sum_ext;
    logic signed [ACC_WIDTH-1:0] sum_sat;
    logic                        sum_ovf;
    logic [COUNT_WIDTH-1:0]      count_inc;
    logic signed [PW-1:0]        carry;
    logic                        carry_avail;

    assign busy      = (state != IDLE);
    assign acc_valid = (state == OUT);

    // One guard bit is enough: a disagreement between the top two bits means overflow.
    always_comb begin
        sum_ext   = {acc[ACC_WIDTH-1], acc} + (ACC_WIDTH+1)'(prod);
        sum_ovf   = sum_ext[ACC_WIDTH] ^ sum_ext[ACC_WIDTH-1];
        sum_sat   = sum_ovf ? (sum_ext[ACC_WIDTH] ? ACC_MIN : ACC_MAX) : sum_ext[ACC_WIDTH-1:0];
        count_inc = count + ONE;
        // A strobe on the handshake cycle counts as having landed in the skid first.
        carry       = skid_full ? skid : prod;
        carry_avail = skid_full || prod_valid;
    end

    // NOTE: every next-state variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_nxt     = state;
        acc_nxt       = acc;
        count_nxt     = count;
        len_nxt       = len_r;
        cont_nxt      = cont_r;
        skid_nxt      = skid;
        skid_full_nxt = skid_full;
        sat_nxt       = acc_sat;
        drop_nxt      = dropped;

        case (state)
            IDLE: begin
                if (prod_valid) drop_nxt = 1'b1;
                if (open) begin
                    len_nxt   = (len == '0) ? ONE : len;
                    cont_nxt  = cont;
                    acc_nxt   = '0;
                    count_nxt = '0;
                    sat_nxt   = 1'b0;
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                if (prod_valid) begin
                    acc_nxt   = sum_sat;
                    count_nxt = count_inc;
                    sat_nxt   = acc_sat | sum_ovf;
                    if (count_inc == len_r) state_nxt = OUT;
                end
            end
            OUT: begin
                if (prod_valid) begin
                    if (skid_full) begin
                        drop_nxt = 1'b1;
                    end else begin
                        skid_nxt      = prod;
                        skid_full_nxt = 1'b1;
                    end
                end
                if (acc_ready) begin
                    skid_full_nxt = 1'b0;
                    if (!cont_r) begin
                        if (carry_avail) drop_nxt = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        // A sign-extended product always fits, so the carried value never saturates.
                        sat_nxt = 1'b0;
                        if (carry_avail) begin
                            acc_nxt   = ACC_WIDTH'(carry);
                            count_nxt = ONE;
                            state_nxt = (len_r == ONE) ? OUT : ACCUM;
                        end else begin
                            acc_nxt   = '0;
                            count_nxt = '0;
                            state_nxt = ACCUM;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (clear) begin
            state_nxt     = IDLE;
            acc_nxt       = '0;
            count_nxt     = '0;
            sat_nxt       = 1'b0;
            skid_full_nxt = 1'b0;
            drop_nxt      = 1'b0;
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the skid data and latched run settings are reset too; cheap, and keeps
            // the block free of X after reset even though the valid flags gate their use.
            state     <= IDLE;
            acc       <= '0;
            count     <= '0;
            len_r     <= ONE;
            cont_r    <= 1'b0;
            skid      <= '0;
            skid_full <= 1'b0;
            acc_sat   <= 1'b0;
            dropped   <= 1'b0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            count     <= count_nxt;
            len_r     <= len_nxt;
            cont_r    <= cont_nxt;
            skid      <= skid_nxt;
            skid_full <= skid_full_nxt;
            acc_sat   <= sat_nxt;
            dropped   <= drop_nxt;
        end
    end

endmodule
